b_seg_display: RTL and testbench

Output-side counterpart to the hex keypad code generator. It accepts an 8-bit operand or result from the calculator datapath and drives a 4-digit multiplexed, common-anode seven-segment display. The display shows the value in hex or unsigned decimal, or an overflow indication. It sits between the calculator core and the board display pins, on the same system clock and reset as the keypad block.

---
 rtl/b_seg_display_if.sv | 32 +++
 rtl/b_seg_display.sv | 152 +++++++++++++++
 tb/tb_b_seg_display.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/b_seg_display_if.sv
// Connection between the calculator core and the seven-segment display driver.
// The core side loads a value and its display mode; the display side returns
// the pin-level digit enables, segment pattern and conversion-busy flag.
interface b_seg_display_if;
    logic [7:0] i_b_seg_value;
    logic       i_b_seg_load;
    logic       i_b_seg_hex_mode;
    logic       i_b_seg_overflow;
    logic [3:0] o_b_seg_anode;
    logic [6:0] o_b_seg_segments;
    logic       o_b_seg_busy;

    modport master (
        output i_b_seg_value,
        output i_b_seg_load,
        output i_b_seg_hex_mode,
        output i_b_seg_overflow,
        input  o_b_seg_anode,
        input  o_b_seg_segments,
        input  o_b_seg_busy
    );

    modport slave (
        input  i_b_seg_value,
        input  i_b_seg_load,
        input  i_b_seg_hex_mode,
        input  i_b_seg_overflow,
        output o_b_seg_anode,
        output o_b_seg_segments,
        output o_b_seg_busy
    );
endinterface

// File: rtl/b_seg_display.sv
// Four-digit multiplexed common-anode seven-segment driver for an 8-bit value.
// Shows hex, unsigned decimal (sequential double-dabble, one iteration per
// cycle) or an overflow "OF" indication. The scan runs continuously from four
// display registers that are always rewritten together.
module b_seg_display #(
    parameter int DIGIT_PERIOD = 16
) (
    input logic             i_sys_clock,
    input logic             i_sys_reset,
    b_seg_display_if.slave  seg_if
);

    localparam int PW = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(DIGIT_PERIOD - 1);

    localparam logic [6:0] BLANK   = 7'b1111111;
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t      state;
    logic [2:0]  iter;
    logic        busy;
    logic [6:0]  disp [4];
    logic [19:0] dd_reg;
    logic [19:0] dd_next;
    logic [3:0]  ones;
    logic [3:0]  tens;
    logic [3:0]  hund;
    logic        dec_load;

    logic [PW-1:0] prescale;
    logic [1:0]    digit;
    logic [1:0]    digit_next;
    logic [3:0]    anode;
    logic [6:0]    segments;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // One double-dabble iteration on {hundreds, tens, ones, binary}:
    // add 3 to every BCD nibble that is 5 or more, then shift left by one.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int k = 0; k < 3; k++) begin
            if (t[8 + 4*k +: 4] >= 4'd5)
                t[8 + 4*k +: 4] = t[8 + 4*k +: 4] + 4'd3;
        end
        dd_step = t << 1;
    endfunction

    assign dd_next  = dd_step(dd_reg);
    assign ones     = dd_next[11:8];
    assign tens     = dd_next[15:12];
    assign hund     = dd_next[19:16];
    assign dec_load = seg_if.i_b_seg_load && !seg_if.i_b_seg_hex_mode && !seg_if.i_b_seg_overflow;

    // Conversion FSM and display registers; a new load always wins over an
    // in-flight conversion, and the final iteration writes all four digits.
    always_ff @(posedge i_sys_clock) begin
        if (i_sys_reset) begin
            state   <= IDLE;
            iter    <= 3'd0;
            busy    <= 1'b0;
            disp[3] <= BLANK;
            disp[2] <= BLANK;
            disp[1] <= GLYPH_0;
            disp[0] <= GLYPH_0;
        end else if (seg_if.i_b_seg_load) begin
            if (seg_if.i_b_seg_overflow) begin
                state   <= IDLE;
                busy    <= 1'b0;
                disp[3] <= BLANK;
                disp[2] <= BLANK;
                disp[1] <= GLYPH_0;
                disp[0] <= GLYPH_F;
            end else if (seg_if.i_b_seg_hex_mode) begin
                state   <= IDLE;
                busy    <= 1'b0;
                disp[3] <= BLANK;
                disp[2] <= BLANK;
                disp[1] <= glyph(seg_if.i_b_seg_value[7:4]);
                disp[0] <= glyph(seg_if.i_b_seg_value[3:0]);
            end else begin
                state <= CONVERT;
                iter  <= 3'd0;
                busy  <= 1'b1;
            end
        end else if (state == CONVERT) begin
            iter <= iter + 3'd1;
            if (iter == 3'd7) begin
                state   <= IDLE;
                busy    <= 1'b0;
                disp[3] <= BLANK;
                disp[2] <= (hund == 4'd0) ? BLANK : glyph(hund);
                disp[1] <= (hund == 4'd0 && tens == 4'd0) ? BLANK : glyph(tens);
                disp[0] <= glyph(ones);
            end
        end
    end

    // Double-dabble shift register; only meaningful while converting.
    always_ff @(posedge i_sys_clock) begin
        if (dec_load)
            dd_reg <= {12'd0, seg_if.i_b_seg_value};
        else if (state == CONVERT)
            dd_reg <= dd_next;
    end

    assign digit_next = (prescale == PRESCALE_LAST) ? digit + 2'd1 : digit;

    // Digit scan: anode and segments register together from the next digit index.
    always_ff @(posedge i_sys_clock) begin
        if (i_sys_reset) begin
            prescale <= '0;
            digit    <= 2'd0;
            anode    <= 4'b1110;
            segments <= GLYPH_0;
        end else begin
            prescale <= (prescale == PRESCALE_LAST) ? '0 : prescale + 1'b1;
            digit    <= digit_next;
            anode    <= ~(4'b0001 << digit_next);
            segments <= disp[digit_next];
        end
    end

    assign seg_if.o_b_seg_anode    = anode;
    assign seg_if.o_b_seg_segments = segments;
    assign seg_if.o_b_seg_busy     = busy;

endmodule

// File: tb/tb_b_seg_display.sv
// Directed bench for b_seg_display: reset scan, hex, decimal, overflow,
// load-during-conversion and reset-during-conversion behaviour.
module tb_b_seg_display;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [6:0] exp_old [4];

    b_seg_display_if bus ();

    b_seg_display #(.DIGIT_PERIOD(16)) dut (
        .i_sys_clock (clk),
        .i_sys_reset (rst),
        .seg_if      (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int aidx(input logic [3:0] a);
        case (a)
            4'b1110: aidx = 0;
            4'b1101: aidx = 1;
            4'b1011: aidx = 2;
            4'b0111: aidx = 3;
            default: aidx = -1;
        endcase
    endfunction

    // Segments must match the previously displayed pattern of the enabled digit.
    task automatic chk_hold(input string tag);
        int i;
        i = aidx(bus.o_b_seg_anode);
        if (i < 0) begin
            checks++;
            errors++;
            $error("FAIL %s: anode %b not one-hot-low", tag, bus.o_b_seg_anode);
        end else begin
            chk(tag, bus.o_b_seg_segments, exp_old[i]);
        end
    endtask

    // Observe each digit in turn as the scan reaches it.
    task automatic check_digits(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                                input logic [6:0] d1, input logic [6:0] d0);
        logic [6:0] e [4];
        logic [3:0] target;
        e[0] = d0; e[1] = d1; e[2] = d2; e[3] = d3;
        step();
        step();
        for (int d = 0; d < 4; d++) begin
            int n;
            n = 0;
            target = ~(4'b0001 << d);
            while (bus.o_b_seg_anode !== target && n < 100) begin
                step();
                n++;
            end
            if (n >= 100) begin
                checks++;
                errors++;
                $error("FAIL %s: digit %0d never enabled, anode %b", tag, d, bus.o_b_seg_anode);
            end else begin
                chk($sformatf("%s_d%0d", tag, d), bus.o_b_seg_segments, e[d]);
            end
        end
        exp_old[0] = d0; exp_old[1] = d1; exp_old[2] = d2; exp_old[3] = d3;
    endtask

    task automatic load(input logic [7:0] v, input logic hex, input logic ovf);
        bus.i_b_seg_value    = v;
        bus.i_b_seg_hex_mode = hex;
        bus.i_b_seg_overflow = ovf;
        bus.i_b_seg_load     = 1'b1;
        step();
        bus.i_b_seg_load     = 1'b0;
    endtask

    // Decimal load, busy for exactly 8 samples with old display held, then write-back.
    task automatic dec_load(input string tag, input logic [7:0] v);
        load(v, 1'b0, 1'b0);
        chk({tag, "_busy0"}, {6'd0, bus.o_b_seg_busy}, 7'd1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("%s_busy%0d", tag, i), {6'd0, bus.o_b_seg_busy}, 7'd1);
            chk_hold($sformatf("%s_hold%0d", tag, i));
        end
        step();
        chk({tag, "_busy_fall"}, {6'd0, bus.o_b_seg_busy}, 7'd0);
    endtask

    initial begin
        bus.i_b_seg_value    = 8'h00;
        bus.i_b_seg_load     = 1'b0;
        bus.i_b_seg_hex_mode = 1'b1;
        bus.i_b_seg_overflow = 1'b0;
        exp_old[0] = G0; exp_old[1] = G0; exp_old[2] = BL; exp_old[3] = BL;

        // Reset and one full scan frame
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        chk("rst_busy", {6'd0, bus.o_b_seg_busy}, 7'd0);
        for (int k = 0; k < 64; k++) begin
            logic [3:0] ea;
            ea = ~(4'b0001 << (k / 16));
            chk($sformatf("rst_anode%0d", k), {3'd0, bus.o_b_seg_anode}, {3'd0, ea});
            chk($sformatf("rst_seg%0d", k), bus.o_b_seg_segments, (k < 32) ? G0 : BL);
            step();
        end
        chk("frame_wrap_anode", {3'd0, bus.o_b_seg_anode}, 7'b0001110);

        // Hex 0xF5
        load(8'hF5, 1'b1, 1'b0);
        chk("hexF5_busy", {6'd0, bus.o_b_seg_busy}, 7'd0);
        check_digits("hexF5", BL, BL, GF, G5);

        // Hex 0x05 keeps the leading zero
        load(8'h05, 1'b1, 1'b0);
        check_digits("hex05", BL, BL, G0, G5);
        load(8'hF5, 1'b1, 1'b0);
        check_digits("hexF5b", BL, BL, GF, G5);

        // Decimal 245
        dec_load("dec245", 8'hF5);
        check_digits("dec245", BL, G2, G4, G5);

        // Decimal 7 then 0
        dec_load("dec7", 8'h07);
        check_digits("dec7", BL, BL, BL, G7);
        dec_load("dec0", 8'h00);
        check_digits("dec0", BL, BL, BL, G0);

        // Overflow in decimal mode
        load(8'hFF, 1'b0, 1'b1);
        chk("ovf_busy", {6'd0, bus.o_b_seg_busy}, 7'd0);
        check_digits("ovf", BL, BL, G0, GF);

        // Decimal 100 restarted by decimal 9 three cycles later
        load(8'h64, 1'b0, 1'b0);
        chk("restart_busy_a", {6'd0, bus.o_b_seg_busy}, 7'd1);
        step();
        step();
        chk_hold("restart_hold_a");
        dec_load("restart9", 8'h09);
        check_digits("restart9", BL, BL, BL, G9);

        // Hex load aborts a conversion
        load(8'hF5, 1'b0, 1'b0);
        step(); step();
        load(8'hF5, 1'b1, 1'b0);
        chk("abort_busy", {6'd0, bus.o_b_seg_busy}, 7'd0);
        for (int i = 0; i < 10; i++) step();
        chk("abort_busy_late", {6'd0, bus.o_b_seg_busy}, 7'd0);
        check_digits("abort", BL, BL, GF, G5);

        // Reset four cycles into a decimal conversion
        load(8'hF5, 1'b0, 1'b0);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", {6'd0, bus.o_b_seg_busy}, 7'd0);
        chk("midrst_anode", {3'd0, bus.o_b_seg_anode}, 7'b0001110);
        chk("midrst_seg", bus.o_b_seg_segments, G0);
        for (int i = 0; i < 10; i++) step();
        chk("midrst_busy_late", {6'd0, bus.o_b_seg_busy}, 7'd0);
        check_digits("midrst", BL, BL, G0, G0);

        // Reset dominates a simultaneous load
        load(8'h09, 1'b1, 1'b0);
        check_digits("pre_dom", BL, BL, G0, G9);
        rst = 1'b1;
        load(8'hF5, 1'b1, 1'b0);
        rst = 1'b0;
        chk("dom_busy", {6'd0, bus.o_b_seg_busy}, 7'd0);
        check_digits("dom", BL, BL, G0, G0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
